// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent clock dividers sharing one system clock.
// Each channel has a runtime-loadable half-period and produces either a 50%
// square wave (period 2*half) or a one-cycle strobe (period half), plus a
// one-cycle tick per output period. A global enable freezes all channels,
// sync_clr re-aligns their phase, and cfg_err latches any attempt to load a
// zero half-period.
module clk_div_multi #(
  parameter int NUM_CH       = 3,
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = 25000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync_clr,
  input  logic [NUM_CH-1:0] div_load,
  input  logic [CNT_W-1:0]  div_value,
  input  logic [NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] L_DEF_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

  // A zero half-period would never reach terminal count, so it is rejected.
  logic w_val_ok;
  assign w_val_ok = (div_value != '0);

  logic r_cfg_err;

  // Sticky error flag: set by any zero-valued load, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cfg_err <= 1'b0;
    end else if ((|div_load) && !w_val_ok) begin
      r_cfg_err <= 1'b1;
    end
  end

  assign cfg_err = r_cfg_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_tick;
    logic             w_term;

    // cnt never exceeds half-1, so this exact compare cannot be skipped over.
    assign w_term = (r_cnt == (r_half - L_ONE));

    // Channel update, priority: sync_clr > div_load > enable-gated counting.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_half <= L_DEF_HALF;
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end else if (sync_clr) begin
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
        if (div_load[g] && w_val_ok) begin
          r_half <= div_value;
        end
      end else if (div_load[g]) begin
        // A rejected (zero) load freezes the channel for this cycle.
        if (w_val_ok) begin
          r_half <= div_value;
          r_cnt  <= '0;
          r_out  <= 1'b0;
          r_tick <= 1'b0;
        end
      end else if (!enable) begin
        r_tick <= 1'b0;
      end else begin
        r_cnt <= w_term ? '0 : (r_cnt + L_ONE);
        if (mode[g]) begin
          // Strobe: one-cycle pulse after each terminal count.
          r_out  <= w_term;
          r_tick <= w_term;
        end else if (w_term) begin
          // Square: toggle; tick marks the 0->1 transition.
          r_out  <= ~r_out;
          r_tick <= ~r_out;
        end else begin
          r_tick <= 1'b0;
        end
      end
    end

    assign clk_out[g] = r_out;
    assign tick[g]    = r_tick;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with NUM_CH=2, CNT_W=4, DEFAULT_HALF=4.
// Expected values are hand-derived cycle by cycle from the divider rules.
module tb_clk_div_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;

  logic              clock;
  logic              reset;
  logic              enable;
  logic              sync_clr;
  logic [NUM_CH-1:0] div_load;
  logic [CNT_W-1:0]  div_value;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic              cfg_err;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .sync_clr (sync_clr),
    .div_load (div_load),
    .div_value(div_value),
    .mode     (mode),
    .clk_out  (clk_out),
    .tick     (tick),
    .cfg_err  (cfg_err)
  );

  // Clock: 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [NUM_CH-1:0] ch, input logic [CNT_W-1:0] val);
    div_load  = ch;
    div_value = val;
    step();
    div_load  = '0;
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b1;
    sync_clr  = 1'b0;
    div_load  = '0;
    div_value = '0;
    mode      = '0;

    // Reset state
    #1;
    check("rst_clk", clk_out, 2'b00);
    check("rst_tick", tick, 2'b00);
    check("rst_err", cfg_err, 1'b0);
    step();
    step();
    check("rst_hold_clk", clk_out, 2'b00);
    #3 reset = 1'b1;  // released between edges

    // Default half=4: first rise 4 cycles after release, period 8
    for (int c = 1; c <= 12; c++) begin
      step();
      check("def_clk", clk_out, (((c / 4) % 2) == 1) ? 2'b11 : 2'b00);
      check("def_tick", tick, ((c % 8) == 4) ? 2'b11 : 2'b00);
    end
    check("def_err", cfg_err, 1'b0);

    // ch0 half=1; ch1 keeps running at half=4 (last rose at cycle 12)
    load(2'b01, 4'd1);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      check("h1_clk", clk_out, {k != 4, (k % 2) == 0});
      check("h1_tick", tick, {1'b0, (k % 2) == 0});
    end

    // ch1 half=3: period 6
    load(2'b10, 4'd3);
    check("h3_load_clk", clk_out, 2'b00);
    check("h3_load_tick", tick, 2'b00);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("h3_clk", clk_out, {((k / 3) % 2) == 1, (k % 2) == 1});
      check("h3_tick", tick, {(k % 6) == 3, (k % 2) == 1});
    end

    // ch1 strobe with half=3, phase-aligned by sync_clr
    mode     = 2'b10;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("clr_clk", clk_out, 2'b00);
    check("clr_tick", tick, 2'b00);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("strb_clk", clk_out, {(k % 3) == 0, (k % 2) == 1});
      check("strb_tick", tick, {(k % 3) == 0, (k % 2) == 1});
    end

    // Strobe with half=1: continuously high
    load(2'b10, 4'd1);
    check("strb1_load_clk", clk_out[1], 1'b0);
    check("strb1_load_tick", tick[1], 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("strb1_clk", clk_out[1], 1'b1);
      check("strb1_tick", tick[1], 1'b1);
    end

    // Enable gating: half=4, freeze at cnt=2 while outputs are high
    mode = 2'b00;
    load(2'b11, 4'd4);
    check("en_load_clk", clk_out, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("en_run_clk", clk_out, (k >= 4) ? 2'b11 : 2'b00);
      check("en_run_tick", tick, (k == 4) ? 2'b11 : 2'b00);
    end
    enable = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("en_hold_clk", clk_out, 2'b11);
      check("en_hold_tick", tick, 2'b00);
    end
    enable = 1'b1;
    step();
    check("en_re1_clk", clk_out, 2'b11);
    step();
    check("en_re2_clk", clk_out, 2'b00);
    check("en_re2_tick", tick, 2'b00);
    check("pre_err", cfg_err, 1'b0);

    // Zero load on ch0: rejected, ch0 frozen one cycle, cfg_err sticky
    load(2'b01, 4'd0);
    check("zero_err", cfg_err, 1'b1);
    check("zero_clk", clk_out, 2'b00);
    step();
    step();
    step();
    check("zero_k3_clk", clk_out, 2'b10);
    check("zero_k3_tick", tick, 2'b10);
    step();
    check("zero_k4_clk", clk_out, 2'b11);
    check("zero_k4_tick", tick, 2'b01);

    // sync_clr with simultaneous load of 5 on ch0
    sync_clr = 1'b1;
    load(2'b01, 4'd5);
    sync_clr = 1'b0;
    check("clrld_clk", clk_out, 2'b00);
    check("clrld_tick", tick, 2'b00);
    check("clrld_err", cfg_err, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("clrld_run_clk", clk_out, {k >= 4, k >= 5});
      check("clrld_run_tick", tick, {k == 4, k == 5});
    end

    // Asynchronous reset mid-period
    #2 reset = 1'b0;
    #1;
    check("areset_clk", clk_out, 2'b00);
    check("areset_tick", tick, 2'b00);
    check("areset_err", cfg_err, 1'b0);
    #3 reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("rel_clk", clk_out, 2'b00);
    end
    // Load on ch0 coincides with its terminal count: no toggle, no tick
    load(2'b01, 4'd2);
    check("ldterm_clk", clk_out, 2'b10);
    check("ldterm_tick", tick, 2'b10);
    step();
    check("ldterm_k5_clk", clk_out, 2'b10);
    check("ldterm_k5_tick", tick, 2'b00);
    step();
    check("ldterm_k6_clk", clk_out, 2'b11);
    check("ldterm_k6_tick", tick, 2'b01);

    // Maximum half-period 2^CNT_W-1 = 15 on ch1
    load(2'b10, 4'd15);
    for (int k = 1; k <= 30; k++) begin
      step();
      check("max_clk", clk_out[1], (k >= 15) && (k < 30));
      check("max_tick", tick[1], k == 15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider for the clock design; generalises the single fixed 0.5 s toggler.
- NUM_CH independent channels, each with a runtime-loadable half-period and a selectable square or strobe output mode.
- Also provides a one-cycle tick per output period, a global run enable and a synchronous phase-align clear.
- Sits between the board oscillator and the seconds/display/blink logic.

Parameters:
- NUM_CH, 3, number of independent divider channels.
- CNT_W, 26, width of the half-period register and counter per channel.
- DEFAULT_HALF, 25000000, half-period loaded into every channel at reset (0.5 s at 50 MHz); must satisfy 1 <= DEFAULT_HALF <= 2^CNT_W-1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global run; 0 freezes all channels.
- sync_clr  in  1  synchronous clear of all counters and outputs, for phase alignment.
- div_load  in  NUM_CH  per-channel load strobe for div_value.
- div_value  in  CNT_W  new half-period, shared by all channels.
- mode  in  NUM_CH  per channel: 0 = square, 1 = strobe.
- clk_out  out  NUM_CH  divided output per channel.
- tick  out  NUM_CH  one-cycle pulse per channel output period.
- cfg_err  out  1  sticky flag: a load with div_value==0 was attempted.

Behaviour:
- Reset (reset=0, asynchronous):
  - half[i]=DEFAULT_HALF, cnt[i]=0, clk_out=0, tick=0, cfg_err=0.
  - Reset mid-count aborts immediately; counting resumes from cnt=0 on the first posedge after release.
- Per-channel priority each posedge: sync_clr > div_load[i] > enable-gated counting.
- sync_clr=1:
  - All cnt=0, clk_out=0, tick=0.
  - half registers keep their value, except a simultaneous valid div_load still captures div_value.
- div_load[i]=1 with div_value!=0:
  - half[i]<=div_value, cnt[i]<=0, clk_out[i]<=0, tick[i]<=0.
  - The new ratio applies from the next cycle.
  - Several div_load bits in one cycle all load the same value.
- div_load[i]=1 with div_value==0:
  - Load ignored; half, cnt and outputs of that channel unchanged that cycle (no counting).
  - cfg_err<=1, cleared only by reset.
- Load coinciding with terminal count: load wins; no toggle and no tick that cycle.
- enable=0 (no clr/load): cnt and clk_out hold; tick forced 0.
- Counting, enable=1:
  - Terminal when cnt==half-1: cnt<=0. Otherwise cnt<=cnt+1.
  - Compare is exact at CNT_W bits; cnt never exceeds half-1, so there is no wrap or overflow.
- Square mode (mode[i]=0):
  - At terminal, clk_out toggles, giving period = 2*half cycles and 50% duty.
  - tick=1 for exactly the cycle in which clk_out has just gone 0->1 (registered alongside clk_out), i.e. once per 2*half cycles.
- Strobe mode (mode[i]=1):
  - clk_out<=1 for the one cycle following each terminal count, else 0; period = half cycles.
  - tick mirrors clk_out.
  - half=1 makes clk_out and tick continuously 1 while enabled.
- Mode change mid-count: takes effect on the next update; cnt is not cleared. In strobe mode, clk_out is recomputed next cycle.
- Latency: a load or clr edge on cycle N is visible on the outputs at N+1.
- Boundary cases:
  - half=1 in square mode: clk_out = clock/2, tick every 2 cycles.
  - half=2^CNT_W-1 must count fully without overflow.

Test Plan:
- Reset with DEFAULT_HALF=4, NUM_CH=2, enable=1, mode=0 -> clk_out[0] first rises 4 cycles after reset release, period 8; tick high 1 cycle per rise; cfg_err=0.
- Load div_value=1 on ch0, div_value=3 on ch1, all mode=0 -> ch0 toggles every cycle (period 2); ch1 period 6; ch1 unaffected by ch0's load.
- Set mode[1]=1 with half=3 -> clk_out[1] = tick[1] = 1-cycle pulse every 3 cycles; then load half=1 -> continuously 1.
- Drop enable for 5 cycles mid-count at cnt=2 -> outputs hold, tick=0; on re-enable, terminal occurs 1 cycle later (half=4).
- Assert div_load with div_value=0 -> half is unchanged, cfg_err=1 and stays 1; assert sync_clr and div_load(5) together -> cnt=0, clk_out=0, half=5.
- Assert reset low mid-period, asynchronously between edges -> all outputs 0 immediately; half returns to DEFAULT_HALF; a load coinciding with terminal count produces no tick.
